// File: rtl/serial_tx.sv
// serial_tx: UART-style frame serializer.
// Takes one DATA_W-bit word over a valid/ready handshake and sends it on a
// single line as start bit (0), data LSB-first, one stop bit (1). Each bit is
// held for CLKS_PER_BIT clocks. The line idles high.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] shift_reg, shift_nx;
  logic [DIV_W-1:0]  div_cnt, div_nx;
  logic [BIT_W-1:0]  bit_cnt, bit_nx;
  logic              tx_out_nx;
  logic              done_nx;
  logic              bit_end;

  // Handshake and status are pure decodes of the registered state.
  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // State, datapath and registered line/done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_out    <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      shift_reg <= shift_nx;
      div_cnt   <= div_nx;
      bit_cnt   <= bit_nx;
      tx_out    <= tx_out_nx;
      done      <= done_nx;
    end
  end

  // Next-state, divider/bit counting and next line level.
  always_comb begin
    state_nx  = state;
    shift_nx  = shift_reg;
    div_nx    = div_cnt;
    bit_nx    = bit_cnt;
    done_nx   = 1'b0;
    tx_out_nx = 1'b1;
    bit_end   = (div_cnt == DIV_LAST);

    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          state_nx = START;
          shift_nx = tx_data;
          div_nx   = '0;
          bit_nx   = '0;
        end
      end
      START: begin
        div_nx = bit_end ? '0 : div_cnt + 1'b1;
        if (bit_end) begin
          state_nx = DATA;
        end
      end
      DATA: begin
        div_nx = bit_end ? '0 : div_cnt + 1'b1;
        if (bit_end) begin
          shift_nx = shift_reg >> 1;
          // Counter is parked at zero after the last bit instead of being
          // incremented, so it never wraps when DATA_W is a power of two.
          if (bit_cnt == BIT_LAST) begin
            state_nx = STOP;
            bit_nx   = '0;
          end else begin
            bit_nx = bit_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        div_nx = bit_end ? '0 : div_cnt + 1'b1;
        if (bit_end) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Line level is decoded from the upcoming state so tx_out can be a flop.
    unique case (state_nx)
      START:   tx_out_nx = 1'b0;
      DATA:    tx_out_nx = shift_nx[0];
      default: tx_out_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: a queue-based line model runs alongside two DUTs
// (CLKS_PER_BIT=4 and CLKS_PER_BIT=1) and is compared on every falling edge;
// directed frames also check hand-computed line patterns and pulse timing.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data0 = 8'h00;
  logic       tx_valid0 = 1'b0;
  logic [7:0] tx_data1 = 8'h00;
  logic       tx_valid1 = 1'b0;
  logic       tx_ready0, tx_out0, busy0, done0;
  logic       tx_ready1, tx_out1, busy1, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .tx_out(tx_out0), .busy(busy0), .done(done0)
  );

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .tx_out(tx_out1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural line model ----------------
  typedef bit bq_t[$];

  // Whole frame as the sequence of line levels, one entry per clock.
  function automatic bq_t frame(input logic [7:0] d, input int c);
    bq_t q;
    for (int i = 0; i < c; i++) q.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < c; i++) q.push_back(d[b]);
    for (int i = 0; i < c; i++) q.push_back(1'b1);
    return q;
  endfunction

  bq_t q0, q1;
  bit  e0_out, e0_busy, e0_done;
  bit  e1_out, e1_busy, e1_done;
  bit  model_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q0.delete(); e0_out = 1'b1; e0_busy = 1'b0; e0_done = 1'b0;
      q1.delete(); e1_out = 1'b1; e1_busy = 1'b0; e1_done = 1'b0;
      model_ok = 1'b1;
    end else begin
      e0_done = 1'b0;
      if (!e0_busy && tx_valid0) q0 = frame(tx_data0, 4);
      if (q0.size() > 0) begin
        e0_out = q0.pop_front(); e0_busy = 1'b1;
      end else begin
        if (e0_busy) e0_done = 1'b1;
        e0_busy = 1'b0; e0_out = 1'b1;
      end
      e1_done = 1'b0;
      if (!e1_busy && tx_valid1) q1 = frame(tx_data1, 1);
      if (q1.size() > 0) begin
        e1_out = q1.pop_front(); e1_busy = 1'b1;
      end else begin
        if (e1_busy) e1_done = 1'b1;
        e1_busy = 1'b0; e1_out = 1'b1;
      end
    end
  end

  // Compare both DUTs against the model every cycle.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("c4_tx_out",   tx_out0,   e0_out);
      chk("c4_busy",     busy0,     e0_busy);
      chk("c4_done",     done0,     e0_done);
      chk("c4_tx_ready", tx_ready0, !e0_busy);
      chk("c1_tx_out",   tx_out1,   e1_out);
      chk("c1_busy",     busy1,     e1_busy);
      chk("c1_done",     done1,     e1_done);
      chk("c1_tx_ready", tx_ready1, !e1_busy);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_in(input int sel, input logic [7:0] d, input logic v);
    if (sel == 0) begin tx_data0 = d; tx_valid0 = v; end
    else          begin tx_data1 = d; tx_valid1 = v; end
  endtask

  // Send one frame and check its line pattern (start..stop, index 0..9)
  // at mid-bit, busy length and the single done pulse position.
  task automatic run_frame(input int sel, input logic [7:0] d,
                           input logic [9:0] pat, input int c,
                           input int chg_at, input int pulse_at);
    int busy_n, done_n, done_at;
    logic o, b, dn;
    logic [7:0] cur;
    logic [9:0] p;
    p = pat; busy_n = 0; done_n = 0; done_at = -1; cur = d;
    @(negedge clk); set_in(sel, cur, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= 12 * c + 4; k++) begin
      @(negedge clk);
      if (k == 1) set_in(sel, cur, 1'b0);
      if (k == chg_at) begin cur = 8'hC3; set_in(sel, cur, 1'b0); end
      if (k == pulse_at) set_in(sel, cur, 1'b1);
      if (k == pulse_at + 1) set_in(sel, cur, 1'b0);
      o  = (sel == 0) ? tx_out0 : tx_out1;
      b  = (sel == 0) ? busy0   : busy1;
      dn = (sel == 0) ? done0   : done1;
      if (b === 1'b1) busy_n++;
      if (dn === 1'b1) begin done_n++; done_at = k; end
      if (k <= 10 * c && ((k - 1) % c) == c / 2)
        chk($sformatf("line_bit%0d", (k - 1) / c), o, p[(k - 1) / c]);
    end
    chki("busy_cycles", busy_n, 10 * c);
    chki("done_count", done_n, 1);
    chki("done_cycle", done_at, 10 * c + 1);
  endtask

  initial begin
    int done_n;
    // Reset held 3 cycles with valid high: nothing may start.
    rst = 1'b1; set_in(0, 8'hFF, 1'b1); set_in(1, 8'hFF, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_out", tx_out0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_ready", tx_ready0, 1'b1);
    chk("rst_c1_busy", busy1, 1'b0);
    rst = 1'b0; set_in(0, 8'h00, 1'b0); set_in(1, 8'h00, 1'b0);
    repeat (2) @(negedge clk);

    // 0xA5 at C=4: 0,1,0,1,0,0,1,0,1,1
    run_frame(0, 8'hA5, 10'b1101001010, 4, -1, -1);

    // Back-to-back 0x00 then 0xFF with valid held high.
    @(negedge clk); set_in(0, 8'h00, 1'b1);
    @(posedge clk);
    done_n = 0;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (k == 1) set_in(0, 8'hFF, 1'b1);
      if (k == 42) set_in(0, 8'hFF, 1'b0);
      if (done0 === 1'b1) done_n++;
      if (k == 20) chk("b2b_zero_data", tx_out0, 1'b0);
      if (k == 40) chk("b2b_stop", tx_out0, 1'b1);
      if (k == 41) begin
        chk("b2b_idle_line", tx_out0, 1'b1);
        chk("b2b_done1", done0, 1'b1);
        chk("b2b_ready", tx_ready0, 1'b1);
      end
      if (k == 42) begin
        chk("b2b_start2", tx_out0, 1'b0);
        chk("b2b_busy2", busy0, 1'b1);
      end
      if (k == 50 || k == 77) chk("b2b_ones", tx_out0, 1'b1);
      if (k == 82) chk("b2b_done2", done0, 1'b1);
      if (k == 85) chk("b2b_no_third", busy0, 1'b0);
    end
    chki("b2b_done_count", done_n, 2);

    // 0x3C with data change and a valid pulse while busy: 0,0,0,1,1,1,1,0,0,1
    run_frame(0, 8'h3C, 10'b1001111000, 4, 10, 20);

    // Reset mid-frame of 0x5A at cycle 15.
    @(negedge clk); set_in(0, 8'h5A, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) set_in(0, 8'h5A, 1'b0);
      if (k == 14) chk("abort_busy_before", busy0, 1'b1);
      if (k == 15) rst = 1'b1;
    end
    @(negedge clk);
    chk("abort_tx_out", tx_out0, 1'b1);
    chk("abort_busy", busy0, 1'b0);
    chk("abort_ready", tx_ready0, 1'b1);
    chk("abort_done", done0, 1'b0);
    rst = 1'b0;
    done_n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done0 === 1'b1) done_n++;
    end
    chki("abort_no_done", done_n, 0);
    chk("abort_ready_after", tx_ready0, 1'b1);

    // C=1, 0x81: 0,1,0,0,0,0,0,0,1,1
    run_frame(1, 8'h81, 10'b1100000010, 1, -1, -1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Frame serializer: accepts one `DATA_W`-bit word over a valid/ready handshake and drives it onto a single line as a UART-style frame: start bit, data LSB-first, one stop bit. Each bit is held for `CLKS_PER_BIT` clocks. It is the transmit end of the link; the sampling receiver built from our D flip-flop stages is the other end. The line idles high and all control is registered in one clock domain.

## Interface
- `DATA_W`, default 8: data bits per frame (≥1).
- `CLKS_PER_BIT`, default 4: clocks each bit is held on the line (≥1).

- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  synchronous, active-high reset, sampled on rising `clk`.
- `tx_data`  in  DATA_W  word to send; sampled only on accept.
- `tx_valid`  in  1  word on `tx_data` is valid.
- `tx_ready`  out  1  high exactly when state is IDLE.
- `tx_out`  out  1  serial line, registered; idles high.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse when a frame completes.

## Operation
- States:
  - IDLE: `tx_out`=1.
  - START: `tx_out`=0.
  - DATA: `tx_out`=shift_reg[0].
  - STOP: `tx_out`=1.
- Accept on a rising edge with `tx_valid && tx_ready`:
  - `tx_data` is latched into `shift_reg`.
  - Bit counter and clock-divider counter clear.
  - State goes to START.
- Divider counts 0..`CLKS_PER_BIT`-1 inside each bit. When it reaches `CLKS_PER_BIT`-1:
  - START → DATA.
  - In DATA, `shift_reg` shifts right by one and the bit counter increments. After bit `DATA_W`-1 the state goes to STOP.
  - STOP → IDLE, with `done` registered high for that one following cycle.
- `tx_data` changes after accept have no effect on the frame in flight.
- `tx_valid` while busy is ignored: not accepted, not queued.
- Counter widths: divider is clog2(`CLKS_PER_BIT`) bits, minimum 1. Bit counter is clog2(`DATA_W`) bits, minimum 1. No wrap is ever reached within a frame.
- `CLKS_PER_BIT`=1: every state lasts exactly one cycle.
- Reset values, the cycle after `rst` is sampled high:
  - state IDLE, `tx_out`=1, `busy`=0, `done`=0, `tx_ready`=1.
  - `shift_reg` and counters = 0.
- Reset mid-frame aborts the frame immediately. The line returns high on the next edge, no `done` pulse is produced, and the partial word is discarded.
- `rst` and `tx_valid` high together: reset wins and nothing is accepted.

## Timing
- Accept at edge E0. START occupies cycles 1..C after E0 (C = `CLKS_PER_BIT`). Data bit i occupies cycles (1+C·(i+1))..(C·(i+2)). STOP occupies the last C cycles.
- Frame length on the line: (`DATA_W`+2)·C cycles. `busy` is high for exactly that many cycles.
- `done`, `tx_ready` and IDLE are all high in cycle (`DATA_W`+2)·C+1 after E0.
- A new accept is allowed in that same cycle. Back-to-back frames therefore carry exactly one idle-high cycle between a stop bit and the next start bit.
- Latency from accept to the falling edge of the start bit: 1 cycle.

## Test plan
- Reset: hold `rst` for 3 cycles with `tx_valid`=1 → `tx_out`=1, `busy`=0, `done`=0, `tx_ready`=1, and no frame starts.
- Single frame, DATA_W=8, C=4, word 0xA5 → line shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 4 cycles. `busy` is high for 40 cycles. `done` pulses in cycle 41 after accept.
- Back-to-back 0x00 then 0xFF with `tx_valid` held high → exactly one idle-high cycle between frames. Second frame shows 0, eight 1s, 1. `done` pulses twice.
- Input stability: change `tx_data` from 0x3C to 0xC3 mid-frame and pulse `tx_valid` while busy → the 0x3C frame is unchanged and no extra frame is sent.
- Reset mid-frame: assert `rst` at cycle 15 of a 0x5A frame → `tx_out`=1 next cycle, no `done`, and `tx_ready`=1 afterwards.
- C=1, DATA_W=8, word 0x81 → 10-cycle frame 0,1,0,0,0,0,0,0,1,1, with `done` in cycle 11.
